// File: rtl/sipo_pkg.sv
// Shared types for the serial-in/parallel-out frame controller: register
// mode-select encoding and controller states.
package sipo_pkg;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_SHL  = 2'd1,
    SEL_SHR  = 2'd2,
    SEL_CLR  = 2'd3
  } sel_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_PRESENT = 2'd2
  } state_e;

endpackage

// File: rtl/shreg_core.sv
// WIDTH-bit multi-mode register: hold, shift left, shift right or clear,
// chosen by sel on each rising edge.
module shreg_core
  import sipo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  sel_e             sel,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the values from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else begin
      case (sel)
        SEL_SHL: q <= {q[WIDTH-2:0], sin};
        SEL_SHR: q <= {sin, q[WIDTH-1:1]};
        SEL_CLR: q <= '0;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame sequencer for shreg_core: counts accepted serial bits, presents the
// finished word with valid/ready, and flags bits that arrive while presenting.
module sipo_frame_ctrl
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     sin,
  input  logic                     sin_valid,
  output logic [WIDTH-1:0]         po,
  output logic                     po_valid,
  input  logic                     po_ready,
  output logic                     busy,
  output logic                     overrun,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic [1:0]               sel_mon
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          overrun_q, overrun_d;
  sel_e          sel;
  sel_e          shift_sel;

  assign shift_sel = MSB_FIRST ? SEL_SHL : SEL_SHR;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;
    sel       = SEL_HOLD;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          sel       = SEL_CLR;
          cnt_d     = '0;
          overrun_d = 1'b0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          sel     = SEL_CLR;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (sin_valid) begin
          sel = shift_sel;
          if (cnt_q == LAST_BIT) begin
            cnt_d   = '0;
            state_d = ST_PRESENT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_PRESENT: begin
        // A bit arriving here is lost; an accepted start still clears the flag.
        if (sin_valid) overrun_d = 1'b1;
        if (abort) begin
          sel     = SEL_CLR;
          state_d = ST_IDLE;
        end else if (po_ready && start) begin
          sel       = SEL_CLR;
          cnt_d     = '0;
          overrun_d = 1'b0;
          state_d   = ST_SHIFT;
        end else if (po_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

  shreg_core #(.WIDTH(WIDTH)) u_shreg (
    .clk (clk),
    .rst (rst),
    .sel (sel),
    .sin (sin),
    .q   (po)
  );

  assign po_valid = (state_q == ST_PRESENT);
  assign busy     = (state_q == ST_SHIFT);
  assign overrun  = overrun_q;
  assign bit_cnt  = cnt_q;
  assign sel_mon  = sel;

endmodule
